// File: rtl/game_engine_if.sv
// Move-offer channel into game_engine: one board position per valid/ready handshake.
// No latency of its own; master holds move_valid/move_row/move_col until the slave raises move_ready.
// Backpressure: move_ready low means the offer is not taken.
interface game_engine_if #(
    parameter int CW = 2
);
    logic          move_valid;
    logic [CW-1:0] move_row;
    logic [CW-1:0] move_col;
    logic          move_ready;

    modport master (output move_valid, move_row, move_col, input  move_ready);
    modport slave  (input  move_valid, move_row, move_col, output move_ready);
endinterface

// File: rtl/game_engine.sv
// N x N, K-in-a-row game engine: owns the board, alternates X/O, rejects illegal moves, reports win/draw.
// Latency: tile written on the accept edge, win/draw/turn result one edge later (max one move per 2 cycles).
// Backpressure: move_ready low during CHECK and OVER; offers are ignored then.
module game_engine #(
    parameter int N  = 3,
    parameter int K  = 3,
    parameter int CW = (N > 1) ? $clog2(N) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              new_game,
    game_engine_if.slave      mv,
    output logic              move_err,
    output logic              turn,
    output logic [2*N*N-1:0]  tiles,
    output logic              game_over,
    output logic [1:0]        winner,
    output logic [N*N-1:0]    color
);
    localparam int NT = N * N;
    localparam int MW = $clog2(NT + 1);

    typedef enum logic [1:0] {PLAY, CHECK, OVER} state_t;

    state_t        state;
    logic [MW-1:0] move_cnt;
    logic [1:0]    mark;
    logic [NT-1:0] sel_hot;
    logic [NT-1:0] own_mask;
    logic [NT-1:0] win_mask;
    logic          legal;

    // Mask of the K-long window starting at (r0,c0) in direction (dr,dc) if every cell
    // belongs to the current mark; zero if the window leaves the board or is incomplete.
    function automatic logic [NT-1:0] full_line(logic [NT-1:0] own, int r0, int c0, int dr, int dc);
        logic [NT-1:0] m;
        int r1;
        int c1;
        m  = '0;
        r1 = r0 + (K - 1) * dr;
        c1 = c0 + (K - 1) * dc;
        if (r1 < 0 || r1 >= N || c1 < 0 || c1 >= N)
            return '0;
        for (int j = 0; j < K; j++)
            m[(r0 + j * dr) * N + (c0 + j * dc)] = 1'b1;
        return ((own & m) == m) ? m : '0;
    endfunction

    // An out-of-range row/col matches no cell, so legal covers both bounds and occupancy.
    always_comb begin
        mark     = turn ? 2'b10 : 2'b01;
        legal    = 1'b0;
        sel_hot  = '0;
        own_mask = '0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                sel_hot[r*N+c]  = (mv.move_row == CW'(r)) && (mv.move_col == CW'(c));
                own_mask[r*N+c] = (tiles[2*(r*N+c) +: 2] == mark);
                if (sel_hot[r*N+c] && tiles[2*(r*N+c) +: 2] == 2'b00)
                    legal = 1'b1;
            end
        end
    end

    always_comb begin
        win_mask = '0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                win_mask = win_mask
                         | full_line(own_mask, r, c, 0, 1)
                         | full_line(own_mask, r, c, 1, 0)
                         | full_line(own_mask, r, c, 1, 1)
                         | full_line(own_mask, r, c, 1, -1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= PLAY;
            mv.move_ready <= 1'b0;
            tiles         <= '0;
            turn          <= 1'b0;
            move_cnt      <= '0;
            move_err      <= 1'b0;
            game_over     <= 1'b0;
            winner        <= 2'b00;
            color         <= '0;
        end else if (new_game) begin
            state         <= PLAY;
            mv.move_ready <= 1'b1;
            tiles         <= '0;
            turn          <= 1'b0;
            move_cnt      <= '0;
            move_err      <= 1'b0;
            game_over     <= 1'b0;
            winner        <= 2'b00;
            color         <= '0;
        end else begin
            move_err <= 1'b0;
            case (state)
                PLAY: begin
                    if (mv.move_valid && mv.move_ready) begin
                        if (legal) begin
                            for (int i = 0; i < NT; i++)
                                if (sel_hot[i]) tiles[2*i +: 2] <= mark;
                            move_cnt      <= move_cnt + MW'(1);
                            mv.move_ready <= 1'b0;
                            state         <= CHECK;
                        end else begin
                            move_err <= 1'b1;
                        end
                    end else begin
                        // First edge after reset release raises ready here.
                        mv.move_ready <= 1'b1;
                    end
                end
                CHECK: begin
                    if (|win_mask) begin
                        winner    <= mark;
                        color     <= win_mask;
                        game_over <= 1'b1;
                        state     <= OVER;
                    end else if (move_cnt == MW'(NT)) begin
                        winner    <= 2'b11;
                        color     <= '0;
                        game_over <= 1'b1;
                        state     <= OVER;
                    end else begin
                        turn          <= ~turn;
                        mv.move_ready <= 1'b1;
                        state         <= PLAY;
                    end
                end
                OVER: begin
                end
                default: state <= PLAY;
            endcase
        end
    end
endmodule

// File: tb/tb_game_engine.sv
// Bench for game_engine: a 3x3/K=3 and a 4x4/K=3 instance checked against a board-array reference model.
module tb_game_engine;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic        ng_a, ng_b;
    logic        err_a, turn_a, over_a, err_b, turn_b, over_b;
    logic [1:0]  win_a, win_b;
    logic [17:0] tiles_a;
    logic [31:0] tiles_b;
    logic [8:0]  color_a;
    logic [15:0] color_b;

    game_engine_if #(.CW(2)) ia ();
    game_engine_if #(.CW(2)) ib ();

    game_engine #(.N(3), .K(3)) dut_a (
        .clk(clk), .reset(reset), .new_game(ng_a), .mv(ia), .move_err(err_a), .turn(turn_a),
        .tiles(tiles_a), .game_over(over_a), .winner(win_a), .color(color_a));
    game_engine #(.N(4), .K(3)) dut_b (
        .clk(clk), .reset(reset), .new_game(ng_b), .mv(ib), .move_err(err_b), .turn(turn_b),
        .tiles(tiles_b), .game_over(over_b), .winner(win_b), .color(color_b));

    int tests = 0;
    int fails = 0;

    // Reference model: board[r][c] holds 0 empty, 1 X, 2 O.
    typedef int board_t [8][8];
    board_t      mb [2];
    int          mn [2] = '{3, 4};
    int          m_turn [2], m_cnt [2], m_over [2], m_win [2];
    logic [15:0] m_color [2];

    task automatic m_clear(int d);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) mb[d][r][c] = 0;
        m_turn[d] = 0; m_cnt[d] = 0; m_over[d] = 0; m_win[d] = 0; m_color[d] = '0;
    endtask

    function automatic logic [15:0] ref_lines(int d, int mark);
        logic [15:0] cm;
        int drs [4] = '{0, 1, 1, 1};
        int dcs [4] = '{1, 0, 1, -1};
        int n, run, rr, cc;
        cm = '0;
        n  = mn[d];
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++)
                for (int q = 0; q < 4; q++) begin
                    run = 0;
                    for (int j = 0; j < 3; j++) begin
                        rr = r + j * drs[q];
                        cc = c + j * dcs[q];
                        if (rr >= 0 && rr < n && cc >= 0 && cc < n && mb[d][rr][cc] == mark) run++;
                    end
                    if (run == 3)
                        for (int j = 0; j < 3; j++) cm[(r + j*drs[q]) * n + c + j*dcs[q]] = 1'b1;
                end
        return cm;
    endfunction

    task automatic m_apply(int d, int r, int c, output logic exp_err);
        logic [15:0] w;
        exp_err = 1'b0;
        if (m_over[d] != 0) return;
        if (r >= mn[d] || c >= mn[d] || mb[d][r][c] != 0) begin
            exp_err = 1'b1;
            return;
        end
        mb[d][r][c] = m_turn[d] + 1;
        m_cnt[d]++;
        w = ref_lines(d, m_turn[d] + 1);
        if (w != 0) begin
            m_win[d] = m_turn[d] + 1; m_color[d] = w; m_over[d] = 1;
        end else if (m_cnt[d] == mn[d] * mn[d]) begin
            m_win[d] = 3; m_color[d] = '0; m_over[d] = 1;
        end else begin
            m_turn[d] = 1 - m_turn[d];
        end
    endtask

    function automatic logic [31:0] m_tiles(int d);
        logic [31:0] t;
        t = '0;
        for (int r = 0; r < mn[d]; r++)
            for (int c = 0; c < mn[d]; c++) t[2*(r*mn[d]+c) +: 2] = 2'(mb[d][r][c]);
        return t;
    endfunction

    // Packed snapshot: {ready, err, turn, over, winner, color[16], tiles[32]}.
    function automatic logic [53:0] obs(int d);
        if (d == 0) return {ia.move_ready, err_a, turn_a, over_a, win_a, 7'b0, color_a, 14'b0, tiles_a};
        return {ib.move_ready, err_b, turn_b, over_b, win_b, color_b, tiles_b};
    endfunction

    function automatic logic [53:0] exp_vec(int d);
        return {1'(m_over[d] == 0), 1'b0, 1'(m_turn[d]), 1'(m_over[d]), 2'(m_win[d]), m_color[d], m_tiles(d)};
    endfunction

    task automatic drive(int d, logic v, int r, int c);
        if (d == 0) begin ia.move_valid = v; ia.move_row = 2'(r); ia.move_col = 2'(c); end
        else        begin ib.move_valid = v; ib.move_row = 2'(r); ib.move_col = 2'(c); end
    endtask

    task automatic pulse_new_game(int d);
        if (d == 0) ng_a = 1'b1; else ng_b = 1'b1;
        @(negedge clk);
        ng_a = 1'b0; ng_b = 1'b0;
        m_clear(d);
    endtask

    // Offer one move at a negedge; returns err/ready/tiles after the accept edge and err one edge later.
    task automatic do_move(int d, int r, int c, output logic e1, output logic y1,
                           output logic [31:0] t1, output logic e2);
        drive(d, 1'b1, r, c);
        @(negedge clk);
        drive(d, 1'b0, 0, 0);
        e1 = (d == 0) ? err_a : err_b;
        y1 = (d == 0) ? ia.move_ready : ib.move_ready;
        t1 = (d == 0) ? {14'b0, tiles_a} : tiles_b;
        @(negedge clk);
        e2 = (d == 0) ? err_a : err_b;
    endtask

    task automatic test_reset;
        @(negedge clk);
        tests++; if (obs(0) !== 54'h0) begin fails++; $display("FAIL reset_a: got %h want 0", obs(0)); end
        tests++; if (obs(1) !== 54'h0) begin fails++; $display("FAIL reset_b: got %h want 0", obs(1)); end
        reset = 1'b1;
        m_clear(0); m_clear(1);
        @(negedge clk);
        tests++; if (obs(0) !== exp_vec(0)) begin fails++; $display("FAIL release_a: got %h want %h", obs(0), exp_vec(0)); end
        tests++; if (obs(1) !== exp_vec(1)) begin fails++; $display("FAIL release_b: got %h want %h", obs(1), exp_vec(1)); end
    endtask

    task automatic test_row_win;
        int rs [5] = '{0, 1, 0, 1, 0};
        int cs [5] = '{0, 0, 1, 1, 2};
        logic xe, e1, y1, e2;
        logic [31:0] t1;
        pulse_new_game(0);
        for (int i = 0; i < 5; i++) begin
            m_apply(0, rs[i], cs[i], xe);
            do_move(0, rs[i], cs[i], e1, y1, t1, e2);
            tests++; if (t1 !== m_tiles(0) || y1 !== 1'b0) begin fails++; $display("FAIL row_accept%0d: tiles %h rdy %b want %h 0", i, t1, y1, m_tiles(0)); end
            tests++; if (obs(0) !== exp_vec(0)) begin fails++; $display("FAIL row_check%0d: got %h want %h", i, obs(0), exp_vec(0)); end
        end
        tests++; if (color_a !== 9'h007 || tiles_a !== 18'h00295 || win_a !== 2'b01 || !over_a)
            begin fails++; $display("FAIL row_final: color %h tiles %h win %b want 007 00295 01", color_a, tiles_a, win_a); end
    endtask

    task automatic test_illegal;
        int rs [2] = '{0, 3};
        int cs [2] = '{0, 0};
        logic xe, e1, y1, e2, ea, eb, ec;
        logic [31:0] t1;
        pulse_new_game(0);
        m_apply(0, 0, 0, xe);
        do_move(0, 0, 0, e1, y1, t1, e2);
        tests++; if (obs(0) !== exp_vec(0)) begin fails++; $display("FAIL ill_setup: got %h want %h", obs(0), exp_vec(0)); end
        for (int i = 0; i < 2; i++) begin
            m_apply(0, rs[i], cs[i], xe);
            do_move(0, rs[i], cs[i], e1, y1, t1, e2);
            tests++; if (e1 !== 1'b1 || e2 !== 1'b0 || y1 !== 1'b1) begin fails++; $display("FAIL ill_pulse%0d: err %b,%b rdy %b want 1,0,1", i, e1, e2, y1); end
            tests++; if (obs(0) !== exp_vec(0)) begin fails++; $display("FAIL ill_hold%0d: got %h want %h", i, obs(0), exp_vec(0)); end
        end
        drive(0, 1'b1, 2, 3);
        @(negedge clk); ea = err_a;
        @(negedge clk); eb = err_a;
        drive(0, 1'b0, 0, 0);
        @(negedge clk); ec = err_a;
        tests++; if ({ea, eb, ec} !== 3'b110) begin fails++; $display("FAIL ill_b2b: got %b want 110", {ea, eb, ec}); end
    endtask

    task automatic test_draw;
        int rs [9] = '{0, 0, 0, 1, 1, 2, 2, 2, 1};
        int cs [9] = '{0, 1, 2, 1, 0, 0, 1, 2, 2};
        logic xe, e1, y1, e2;
        logic [31:0] t1;
        pulse_new_game(0);
        for (int i = 0; i < 9; i++) begin
            m_apply(0, rs[i], cs[i], xe);
            do_move(0, rs[i], cs[i], e1, y1, t1, e2);
            tests++; if (obs(0) !== exp_vec(0)) begin fails++; $display("FAIL draw%0d: got %h want %h", i, obs(0), exp_vec(0)); end
        end
        tests++; if (win_a !== 2'b11 || color_a !== 9'h0 || !over_a) begin fails++; $display("FAIL draw_final: win %b color %h want 11 000", win_a, color_a); end
        do_move(0, 1, 1, e1, y1, t1, e2);
        tests++; if (e1 !== 1'b0 || e2 !== 1'b0 || obs(0) !== exp_vec(0)) begin fails++; $display("FAIL draw_ignore: err %b obs %h want 0 %h", e1, obs(0), exp_vec(0)); end
    endtask

    task automatic test_n4_diag;
        int rs [5] = '{1, 0, 2, 0, 3};
        int cs [5] = '{0, 0, 1, 3, 2};
        logic xe, e1, y1, e2;
        logic [31:0] t1;
        pulse_new_game(1);
        for (int i = 0; i < 5; i++) begin
            m_apply(1, rs[i], cs[i], xe);
            do_move(1, rs[i], cs[i], e1, y1, t1, e2);
            tests++; if (obs(1) !== exp_vec(1)) begin fails++; $display("FAIL n4_move%0d: got %h want %h", i, obs(1), exp_vec(1)); end
        end
        tests++; if (color_b !== 16'h4210 || win_b !== 2'b01) begin fails++; $display("FAIL n4_color: color %h win %b want 4210 01", color_b, win_b); end
    endtask

    task automatic test_new_game_in_check;
        int rs [4] = '{0, 1, 0, 1};
        int cs [4] = '{0, 0, 1, 1};
        logic xe, e1, y1, e2;
        logic [31:0] t1;
        pulse_new_game(0);
        for (int i = 0; i < 4; i++) begin
            m_apply(0, rs[i], cs[i], xe);
            do_move(0, rs[i], cs[i], e1, y1, t1, e2);
        end
        drive(0, 1'b1, 0, 2);
        @(negedge clk);
        drive(0, 1'b0, 0, 0);
        ng_a = 1'b1;
        @(negedge clk);
        ng_a = 1'b0;
        m_clear(0);
        tests++; if (obs(0) !== exp_vec(0)) begin fails++; $display("FAIL ng_check: got %h want %h", obs(0), exp_vec(0)); end
    endtask

    task automatic test_async_reset;
        logic xe, e1, y1, e2;
        logic [31:0] t1;
        pulse_new_game(0);
        m_apply(0, 1, 1, xe);
        do_move(0, 1, 1, e1, y1, t1, e2);
        #2 reset = 1'b0;
        #1;
        tests++; if (obs(0) !== 54'h0) begin fails++; $display("FAIL areset_clear: got %h want 0", obs(0)); end
        @(negedge clk);
        reset = 1'b1;
        m_clear(0); m_clear(1);
        @(negedge clk);
        m_apply(0, 2, 0, xe);
        do_move(0, 2, 0, e1, y1, t1, e2);
        tests++; if (t1[13:12] !== 2'b01 || e1 !== 1'b0 || obs(0) !== exp_vec(0))
            begin fails++; $display("FAIL areset_first: tile %b obs %h want 01 %h", t1[13:12], obs(0), exp_vec(0)); end
    endtask

    task automatic test_random;
        logic xe, e1, y1, e2;
        logic [31:0] t1;
        int r, c, steps;
        for (int g = 0; g < 25; g++) begin
            pulse_new_game(0);
            steps = 0;
            while (m_over[0] == 0 && steps < 40) begin
                r = $urandom_range(0, 3);
                c = $urandom_range(0, 3);
                m_apply(0, r, c, xe);
                do_move(0, r, c, e1, y1, t1, e2);
                tests++; if (e1 !== xe || y1 !== xe || t1 !== m_tiles(0))
                    begin fails++; $display("FAIL rnd_edge g%0d (%0d,%0d): err %b rdy %b tiles %h want %b %b %h", g, r, c, e1, y1, t1, xe, xe, m_tiles(0)); end
                tests++; if (obs(0) !== exp_vec(0))
                    begin fails++; $display("FAIL rnd_state g%0d (%0d,%0d): got %h want %h", g, r, c, obs(0), exp_vec(0)); end
                steps++;
            end
            do_move(0, $urandom_range(0, 2), $urandom_range(0, 2), e1, y1, t1, e2);
            tests++; if (m_over[0] != 0 && (e1 !== 1'b0 || obs(0) !== exp_vec(0)))
                begin fails++; $display("FAIL rnd_over g%0d: err %b obs %h want 0 %h", g, e1, obs(0), exp_vec(0)); end
        end
    endtask

    initial begin
        ng_a = 1'b0; ng_b = 1'b0;
        drive(0, 1'b0, 0, 0);
        drive(1, 1'b0, 0, 0);
        test_reset;
        test_row_win;
        test_illegal;
        test_draw;
        test_n4_diag;
        test_new_game_in_check;
        test_async_reset;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests %0d", tests);
        $fatal(1);
    end
endmodule
